// File: rtl/flash_read_responder.sv
// Responder side of the flash read handshake: turns a CE/OE read strobe into one
// Avalon-MM pipelined read and returns the data via read_ready/data_valid/read_done.
module flash_read_responder #(
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              CE,
   input  logic              OE,
   input  logic [ADDR_W-1:0] address,
   output logic              read_ready,
   output logic              data_valid,
   output logic              read_done,
   output logic [DATA_W-1:0] read_data,
   output logic              timeout_err,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DATA,
      S_PRESENT,
      S_COMPLETE
   } state_t;

   state_t              r_state;
   logic                r_abort;
   logic [CNT_W-1:0]    r_count;
   logic [DATA_W-1:0]   r_read_data;
   logic                r_timeout_err;
   logic [ADDR_W-1:0]   r_avm_address;

   logic w_request;
   logic w_release;
   logic w_abort_now;
   logic w_timeout;

   assign w_request   = !CE && !OE;
   assign w_release   = CE || OE;
   // An abort seen on the same edge as the response still discards it.
   assign w_abort_now = r_abort || w_release;
   assign w_timeout   = (r_count == CNT_LAST);

   // Handshake flags are pure decodes of the state register, so they never glitch.
   assign avm_read    = (r_state == S_ISSUE);
   assign read_ready  = (r_state == S_WAIT_DATA) && !r_abort;
   assign data_valid  = (r_state == S_PRESENT);
   assign read_done   = (r_state == S_COMPLETE);
   assign read_data   = r_read_data;
   assign timeout_err = r_timeout_err;
   assign avm_address = r_avm_address;

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the same pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_abort       <= 1'b0;
         r_count       <= '0;
         r_read_data   <= '0;
         r_timeout_err <= 1'b0;
         r_avm_address <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_request) begin
                  r_avm_address <= address;
                  r_timeout_err <= 1'b0;
                  r_abort       <= 1'b0;
                  r_state       <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (w_release) begin
                  r_abort <= 1'b1;
               end
               // The command must complete on the bus even if the requester aborted.
               if (!avm_waitrequest) begin
                  r_count <= '0;
                  r_state <= S_WAIT_DATA;
               end
            end

            S_WAIT_DATA: begin
               if (avm_readdatavalid) begin
                  if (w_abort_now) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_read_data <= avm_readdata;
                     r_state     <= S_PRESENT;
                  end
               end else if (w_timeout) begin
                  r_timeout_err <= 1'b1;
                  if (w_abort_now) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_read_data <= '1;
                     r_state     <= S_PRESENT;
                  end
               end else begin
                  r_count <= r_count + CNT_W'(1);
                  if (w_release) begin
                     r_abort <= 1'b1;
                  end
               end
            end

            S_PRESENT: begin
               if (CE) begin
                  r_state <= S_COMPLETE;
               end
            end

            S_COMPLETE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench for flash_read_responder: cycle-exact handshake, wait states,
// timeout, abort, mid-transaction reset and a run of back-to-back reads.
module tb_flash_read_responder;

   localparam int ADDR_W  = 23;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;

   logic              CLK = 1'b0;
   logic              reset;
   logic              CE;
   logic              OE;
   logic [ADDR_W-1:0] address;
   logic              read_ready;
   logic              data_valid;
   logic              read_done;
   logic [DATA_W-1:0] read_data;
   logic              timeout_err;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   logic [DATA_W-1:0] last_data;

   flash_read_responder #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK              (CLK),
      .reset            (reset),
      .CE               (CE),
      .OE               (OE),
      .address          (address),
      .read_ready       (read_ready),
      .data_valid       (data_valid),
      .read_done        (read_done),
      .read_data        (read_data),
      .timeout_err      (timeout_err),
      .avm_address      (avm_address),
      .avm_read         (avm_read),
      .avm_waitrequest  (avm_waitrequest),
      .avm_readdata     (avm_readdata),
      .avm_readdatavalid(avm_readdatavalid)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs and outputs are handled 1 ns after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".avm_read"},    avm_read,    0);
      check({tag, ".read_ready"},  read_ready,  0);
      check({tag, ".data_valid"},  data_valid,  0);
      check({tag, ".read_done"},   read_done,   0);
      check({tag, ".timeout_err"}, timeout_err, 0);
      check({tag, ".read_data"},   read_data,   0);
      check({tag, ".avm_address"}, avm_address, 0);
   endtask

   // Requester + slave model for one complete read with ws wait states and lat idle cycles.
   task automatic do_read(input logic [ADDR_W-1:0] a, input int ws, input int lat,
                          input logic [DATA_W-1:0] d);
      int cyc;
      CE = 1'b0; OE = 1'b0; address = a; avm_readdatavalid = 1'b0;
      avm_waitrequest = (ws > 0);
      step();
      check("rd.issue_addr", avm_address, a);
      check("rd.issue_terr", timeout_err, 0);
      cyc = 0;
      while (!read_ready && cyc < 40) begin
         avm_waitrequest = (cyc < ws);
         step();
         cyc++;
      end
      avm_waitrequest = 1'b0;
      check("rd.accept_cycles", cyc, ws + 1);
      for (int k = 0; k < lat; k++) step();
      avm_readdatavalid = 1'b1; avm_readdata = d;
      step();
      avm_readdatavalid = 1'b0;
      check("rd.data_valid", data_valid, 1);
      check("rd.read_data", read_data, d);
      CE = 1'b1; OE = 1'b1;
      step();
      check("rd.read_done", read_done, 1);
      if (read_done) n_done++;
      step();
      check("rd.done_one_cycle", read_done, 0);
      last_data = d;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; CE = 1'b1; OE = 1'b1; address = '0;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
      step(); step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // Single read, zero wait states, data one cycle after accept.
      CE = 1'b0; OE = 1'b0; address = 23'h001234;
      step();
      check("t1.avm_read_c1", avm_read, 1);
      check("t1.avm_addr_c1", avm_address, 23'h001234);
      check("t1.rready_c1", read_ready, 0);
      step();
      check("t1.rready_c2", read_ready, 1);
      check("t1.avm_read_c2", avm_read, 0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
      step();
      avm_readdatavalid = 1'b0;
      check("t1.dvalid_c3", data_valid, 1);
      check("t1.rdata_c3", read_data, 32'hDEADBEEF);
      check("t1.rready_c3", read_ready, 0);
      step();
      check("t1.dvalid_held", data_valid, 1);
      CE = 1'b1; OE = 1'b1;
      step();
      check("t1.dvalid_fall", data_valid, 0);
      check("t1.read_done", read_done, 1);
      step();
      check("t1.done_fall", read_done, 0);

      // Four wait states, max address.
      CE = 1'b0; OE = 1'b0; address = 23'h7FFFFF; avm_waitrequest = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         check("t2.avm_read_wait", avm_read, 1);
         check("t2.addr_stable", avm_address, 23'h7FFFFF);
         check("t2.rready_wait", read_ready, 0);
         address = 23'h000055;
         step();
      end
      avm_waitrequest = 1'b0;
      check("t2.avm_read_c5", avm_read, 1);
      step();
      check("t2.avm_read_drop", avm_read, 0);
      check("t2.rready", read_ready, 1);
      avm_readdatavalid = 1'b1; avm_readdata = 32'hA5A50001;
      step();
      avm_readdatavalid = 1'b0;
      check("t2.rdata", read_data, 32'hA5A50001);
      CE = 1'b1; OE = 1'b1;
      step();
      check("t2.read_done", read_done, 1);
      step();

      // Timeout: no response for TIMEOUT cycles.
      CE = 1'b0; OE = 1'b0; address = 23'h000100;
      step();
      step();
      for (int i = 0; i < TIMEOUT; i++) begin
         check("t3.rready_wait", read_ready, 1);
         check("t3.no_dvalid", data_valid, 0);
         step();
      end
      check("t3.dvalid", data_valid, 1);
      check("t3.rdata_ones", read_data, 32'hFFFFFFFF);
      check("t3.terr", timeout_err, 1);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h00001111;
      step();
      avm_readdatavalid = 1'b0;
      check("t3.late_ignored", read_data, 32'hFFFFFFFF);
      CE = 1'b1; OE = 1'b1;
      step();
      check("t3.read_done", read_done, 1);
      step();
      check("t3.terr_sticky", timeout_err, 1);
      do_read(23'h000200, 0, 1, 32'h12345678);

      // Abort during ISSUE with three wait states.
      CE = 1'b0; OE = 1'b0; address = 23'h000300; avm_waitrequest = 1'b1;
      step();
      CE = 1'b1; OE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t4.avm_read_held", avm_read, 1);
         step();
      end
      avm_waitrequest = 1'b0;
      check("t4.avm_read_c4", avm_read, 1);
      step();
      check("t4.avm_read_drop", avm_read, 0);
      check("t4.rready_suppressed", read_ready, 0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD0BAD0;
      step();
      avm_readdatavalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t4.no_dvalid", data_valid, 0);
         check("t4.no_done", read_done, 0);
         check("t4.rdata_kept", read_data, last_data);
         step();
      end
      do_read(23'h000301, 1, 0, 32'hCAFEF00D);

      // Reset in WAIT_DATA.
      CE = 1'b0; OE = 1'b0; address = 23'h000400;
      step();
      step();
      check("t5.in_wait", read_ready, 1);
      reset = 1'b1;
      step();
      check_all_zero("t5.reset");
      reset = 1'b0; CE = 1'b1; OE = 1'b1;
      step();
      do_read(23'h000401, 2, 2, 32'h0BADC0DE);

      // Back-to-back random reads.
      n_done = 0;
      for (int i = 0; i < 100; i++) begin
         logic [ADDR_W-1:0] a;
         a = ADDR_W'($urandom);
         do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                 {9'h0A5, a} ^ 32'h5A5A_0000);
      end
      check("t6.done_count", n_done, 100);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/flash_read_responder.md
# flash_read_responder

Responder end of the flash read handshake: accepts a read strobe (active-low CE/OE plus address) from a read-requester FSM, issues one Avalon-MM pipelined read to the flash/memory controller, and returns the data through the three-flag handshake the requester waits on (read_ready, data_valid, read_done). Sits between the requester FSM and the memory-controller Avalon slave. Adds a response timeout so a stalled slave cannot hang the requester.

## Interface
- ADDR_W, 23, address width (word address)
- DATA_W, 32, read data width
- TIMEOUT, 255, max cycles in WAIT_DATA before forced completion (≥2)

- CLK  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- CE  in  1  chip enable from requester, active-low
- OE  in  1  output enable from requester, active-low
- address  in  ADDR_W  read address, sampled when request accepted
- read_ready  out  1  command accepted by slave (requester's waitRead)
- data_valid  out  1  read_data valid (requester's waitOutput)
- read_done  out  1  transaction complete (requester's waitComplete)
- read_data  out  DATA_W  registered read result
- timeout_err  out  1  last transaction timed out
- avm_address  out  ADDR_W  Avalon address
- avm_read  out  1  Avalon read command
- avm_waitrequest  in  1  Avalon stall
- avm_readdata  in  DATA_W  Avalon read data
- avm_readdatavalid  in  1  Avalon read data valid

## Operation
- Request = CE==0 && OE==0, sampled at rising edge.
- States: IDLE, ISSUE, WAIT_DATA, PRESENT, COMPLETE. Flags are Moore decodes of state.
- IDLE: request → latch address into avm_address, clear timeout_err, clear abort, → ISSUE.
- ISSUE: avm_read=1, avm_address stable. Edge with avm_waitrequest==0 → WAIT_DATA, counter cleared. avm_readdatavalid ignored in ISSUE.
- WAIT_DATA: read_ready=1 (unless abort). avm_readdatavalid → read_data<=avm_readdata, → PRESENT. Else counter+1; counter==TIMEOUT-1 without valid → read_data<=all ones, timeout_err<=1, → PRESENT.
- PRESENT: data_valid=1; held until CE==1 sampled → COMPLETE.
- COMPLETE: read_done=1 for exactly one cycle → IDLE.
- Abort: CE or OE high sampled in ISSUE or WAIT_DATA sets abort. Avalon command still held until accepted; WAIT_DATA still waits for valid or timeout (data discarded, read_data unchanged). Then → IDLE directly; no data_valid, no read_done, read_ready suppressed once abort set. timeout_err still set if timeout occurred.
- avm_readdatavalid outside WAIT_DATA ignored (late response after timeout discarded).
- Counter width clog2(TIMEOUT+1); no wrap possible (exits at TIMEOUT-1).
- timeout_err sticky until next IDLE→ISSUE.

## Timing
- Reset: state IDLE; avm_read, read_ready, data_valid, read_done, timeout_err = 0; read_data, avm_address, counter = 0; abort cleared. Reset mid-transaction drops avm_read next cycle without completing the Avalon command.
- Min latency: request sampled edge 0 → avm_read high cycle 1 → accepted edge 1 → read_ready cycle 2 → readdatavalid in cycle 2 → data_valid from cycle 3.
- Each cycle of avm_waitrequest=1 adds one cycle in ISSUE; each cycle without readdatavalid adds one in WAIT_DATA.
- Timeout: WAIT_DATA lasts exactly TIMEOUT cycles, data_valid rises next cycle.
- data_valid falls one cycle after CE==1 sampled; read_done high that cycle only.
- Back-to-back: request sampled in cycle after read_done (IDLE) starts next transaction; no dead cycle beyond IDLE.
- CE high and readdatavalid same edge in WAIT_DATA: treated as abort (data discarded, → IDLE).

## Test plan
- Single read, waitrequest=0, readdata=0xDEADBEEF one cycle after accept at addr 0x00_1234 → avm_address=0x001234, data_valid cycle 3 with read_data=0xDEADBEEF, read_done one cycle after CE rises.
- waitrequest held 4 cycles → avm_read high 5 cycles, address stable, read_ready only after acceptance.
- TIMEOUT=8, no readdatavalid → WAIT_DATA 8 cycles, read_data=0xFFFFFFFF, timeout_err=1; next request clears timeout_err; late readdatavalid ignored.
- CE released during ISSUE with waitrequest=1 for 3 cycles → avm_read held until accept, return to IDLE after data, data_valid and read_done never assert, read_data unchanged.
- Reset asserted in WAIT_DATA → next cycle all outputs 0, state IDLE; new read then completes normally.
- Run the requester FSM against the block for 100 back-to-back reads with random waitrequest/latency → every read returns correct data, no hang, one read_done per read.
